// File: rtl/adc_runup_ctl.sv
// adc_runup_ctl
//   Run-up integrating ADC controller. Each accepted start shorts the
//   integrator for INT_RESET_CLKS clocks, then integrates for the latched
//   aperture in fixed RUNUP_PERIOD windows. At the start of every window
//   the comparator chooses -ref (integrator above zero) or +ref. The bench
//   of +ref / -ref windows is reported when the conversion finishes.
//
// Handshake: adc_measure_start is sampled on every posedge but is only
//   accepted in IDLE; it is neither queued nor acknowledged otherwise.
//   adc_measure_done is a 1-clk pulse, and count_pos/count_neg are valid
//   from that edge until the next accepted start.
//
// Ports
//   clk                   in   system clock
//   reset                 in   asynchronous, active-high
//   adc_measure_start     in   conversion request
//   clk_count_aperture_n  in   aperture in clks, latched when start is accepted
//   comparator_val        in   1 = integrator above zero
//   adc_measure_done      out  1-clk completion pulse
//   busy                  out  conversion in progress
//   sw_int_reset          out  1 = integrator shorted
//   refmux                out  00 off, 01 +ref, 10 -ref
//   count_pos             out  +ref windows in the last conversion
//   count_neg             out  -ref windows in the last conversion
//   monitor               out  [0] integrating, [1] copy of done pulse
module adc_runup_ctl #(
  parameter int RUNUP_PERIOD   = 20,
  parameter int INT_RESET_CLKS = 2000,
  parameter int CW             = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adc_measure_start,
  input  logic [CW-1:0] clk_count_aperture_n,
  input  logic          comparator_val,
  output logic          adc_measure_done,
  output logic          busy,
  output logic          sw_int_reset,
  output logic [1:0]    refmux,
  output logic [CW-1:0] count_pos,
  output logic [CW-1:0] count_neg,
  output logic [1:0]    monitor
);

  typedef enum logic [1:0] {IDLE, INT_RESET, INTEGRATE, DONE} state_t;

  // One phase counter serves both the shorting interval and the run-up window.
  localparam int PMAX = (INT_RESET_CLKS > RUNUP_PERIOD) ? INT_RESET_CLKS : RUNUP_PERIOD;
  localparam int PW   = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] RST_LAST = PW'(INT_RESET_CLKS - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(RUNUP_PERIOD - 1);

  state_t        state, nxt_state;
  logic [PW-1:0] phase, nxt_phase;
  // One extra bit: elapsed can exceed the aperture by up to RUNUP_PERIOD-1.
  logic [CW:0]   elapsed, nxt_elapsed, elapsed_plus;
  logic [CW-1:0] aperture, nxt_aperture;
  logic [CW-1:0] nxt_count_pos, nxt_count_neg;
  logic          nxt_done, nxt_busy, nxt_sw;
  logic [1:0]    nxt_refmux, nxt_monitor;
  logic          take_decision;

  assign elapsed_plus = elapsed + (CW+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      phase            <= '0;
      elapsed          <= '0;
      aperture         <= '0;
      count_pos        <= '0;
      count_neg        <= '0;
      adc_measure_done <= 1'b0;
      busy             <= 1'b0;
      sw_int_reset     <= 1'b1;
      refmux           <= 2'b00;
      monitor          <= 2'b00;
    end else begin
      state            <= nxt_state;
      phase            <= nxt_phase;
      elapsed          <= nxt_elapsed;
      aperture         <= nxt_aperture;
      count_pos        <= nxt_count_pos;
      count_neg        <= nxt_count_neg;
      adc_measure_done <= nxt_done;
      busy             <= nxt_busy;
      sw_int_reset     <= nxt_sw;
      refmux           <= nxt_refmux;
      monitor          <= nxt_monitor;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_phase     = phase;
    nxt_elapsed   = elapsed;
    nxt_aperture  = aperture;
    nxt_count_pos = count_pos;
    nxt_count_neg = count_neg;
    nxt_done      = adc_measure_done;
    nxt_busy      = busy;
    nxt_sw        = sw_int_reset;
    nxt_refmux    = refmux;
    nxt_monitor   = monitor;
    take_decision = 1'b0;

    case (state)
      IDLE: begin
        if (adc_measure_start) begin
          nxt_aperture  = clk_count_aperture_n;
          nxt_count_pos = '0;
          nxt_count_neg = '0;
          nxt_busy      = 1'b1;
          nxt_phase     = '0;
          nxt_state     = INT_RESET;
        end
      end
      INT_RESET: begin
        if (phase == RST_LAST) begin
          // Releasing the short and taking the first decision share this edge.
          nxt_sw         = 1'b0;
          nxt_monitor[0] = 1'b1;
          nxt_elapsed    = '0;
          take_decision  = 1'b1;
          nxt_state      = INTEGRATE;
        end else begin
          nxt_phase = phase + PW'(1);
        end
      end
      INTEGRATE: begin
        nxt_elapsed = elapsed_plus;
        if (phase == PER_LAST) begin
          // Every boundary has at least one window behind it, so aperture 0
          // still yields exactly one window.
          if (elapsed_plus >= {1'b0, aperture}) begin
            nxt_refmux  = 2'b00;
            nxt_done    = 1'b1;
            nxt_monitor = 2'b10;
            nxt_state   = DONE;
          end else begin
            take_decision = 1'b1;
          end
        end else begin
          nxt_phase = phase + PW'(1);
        end
      end
      DONE: begin
        nxt_done       = 1'b0;
        nxt_monitor[1] = 1'b0;
        nxt_busy       = 1'b0;
        nxt_sw         = 1'b1;
        nxt_state      = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    // Integrator above zero -> apply -ref to pull it down, else +ref.
    if (take_decision) begin
      nxt_phase = '0;
      if (comparator_val) begin
        nxt_refmux    = 2'b10;
        nxt_count_neg = count_neg + CW'(1);
      end else begin
        nxt_refmux    = 2'b01;
        nxt_count_pos = count_pos + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_runup_ctl.sv
// tb_adc_runup_ctl
//   Scoreboarded bench for adc_runup_ctl with RUNUP_PERIOD=4, INT_RESET_CLKS=3.
//   The driver computes, per conversion, the window count and the comparator
//   decisions it will present, pushes the expected result and done cycle,
//   and checks the per-cycle output trace from a timeline model. A separate
//   monitor pops the expectation whenever done pulses.
module tb_adc_runup_ctl;
  localparam int R  = 4;
  localparam int K  = 3;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          adc_measure_start = 1'b0;
  logic [CW-1:0] ap_in = '0;
  logic          comparator_val = 1'b0;
  logic          adc_measure_done, busy, sw_int_reset;
  logic [1:0]    refmux, monitor;
  logic [CW-1:0] count_pos, count_neg;

  adc_runup_ctl #(.RUNUP_PERIOD(R), .INT_RESET_CLKS(K), .CW(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .adc_measure_start    (adc_measure_start),
    .clk_count_aperture_n (ap_in),
    .comparator_val       (comparator_val),
    .adc_measure_done     (adc_measure_done),
    .busy                 (busy),
    .sw_int_reset         (sw_int_reset),
    .refmux               (refmux),
    .count_pos            (count_pos),
    .count_neg            (count_neg),
    .monitor              (monitor)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [2*CW-1:0] exp_q[$];
  int              exp_cyc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon_blk
    logic [2*CW-1:0] e;
    int              ec;
    if (!reset && adc_measure_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("done_cycle", cyc, ec);
        chk("done_count_pos", int'(count_pos), int'(e[2*CW-1:CW]));
        chk("done_count_neg", int'(count_neg), int'(e[CW-1:0]));
        chk("done_monitor", int'(monitor), 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_sw", int'(sw_int_reset), 1);
      chk("idle_refmux", int'(refmux), 0);
      chk("idle_monitor", int'(monitor), 0);
    end
  endtask

  // Called at a negedge. mode: 0 random decisions, 1 all ones, 2 alternate
  // starting 0. rp: 0 start dropped, 1 random re-pulses, 2 held high.
  // chain: leave start high after DONE so the next call retriggers at once.
  task automatic run_conv(input int ap, input int mode, input int rp, input bit chain);
    int n, e0, last, pos, neg, exp_ref;
    bit bits[$];
    n = (ap + R - 1) / R;
    if (n < 1) n = 1;
    pos = 0;
    neg = 0;
    for (int i = 0; i < n; i++) begin
      bit b;
      case (mode)
        0:       b = 1'($urandom_range(0, 1));
        1:       b = 1'b1;
        default: b = (i % 2) == 1;
      endcase
      bits.push_back(b);
      if (b) neg++; else pos++;
    end
    ap_in = CW'(ap);
    adc_measure_start = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back({CW'(pos), CW'(neg)});
    exp_cyc_q.push_back(e0 + K + n * R);
    last = K + n * R;
    pos = 0;
    neg = 0;
    for (int c = 0; c <= last; c++) begin
      bit dec;
      dec = (c >= K) && (((c - K) % R) == 0) && (c < last);
      comparator_val = dec ? bits[(c - K) / R] : 1'($urandom_range(0, 1));
      if (c >= 1) begin
        adc_measure_start = (rp == 2) ? 1'b1 : (rp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        ap_in = CW'($urandom_range(0, 200));
      end
      @(negedge clk);
      if (dec) begin
        if (bits[(c - K) / R]) neg++; else pos++;
      end
      if (c < K || c == last) exp_ref = 0;
      else exp_ref = bits[(c - K) / R] ? 2 : 1;
      chk("busy", int'(busy), 1);
      chk("sw_int_reset", int'(sw_int_reset), (c < K) ? 1 : 0);
      chk("refmux", int'(refmux), exp_ref);
      chk("count_pos", int'(count_pos), pos);
      chk("count_neg", int'(count_neg), neg);
      chk("monitor", int'(monitor), (c == last) ? 2 : (c >= K) ? 1 : 0);
    end
    // This edge lands in DONE; a start here must be ignored.
    adc_measure_start = (chain || rp != 0) ? 1'b1 : 1'b0;
    @(negedge clk);
    chk("end_busy", int'(busy), 0);
    chk("end_sw", int'(sw_int_reset), 1);
    chk("end_refmux", int'(refmux), 0);
    chk("end_monitor", int'(monitor), 0);
    chk("end_done", int'(adc_measure_done), 0);
    chk("hold_count_pos", int'(count_pos), pos);
    chk("hold_count_neg", int'(count_neg), neg);
    chk("sum_counts", int'(count_pos) + int'(count_neg), n);
    adc_measure_start = chain;
  endtask

  task automatic abort_test();
    ap_in = CW'(20);
    adc_measure_start = 1'b1;
    @(negedge clk);
    adc_measure_start = 1'b0;
    for (int i = 0; i < K + 5; i++) begin
      comparator_val = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("abort_pre_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_done", int'(adc_measure_done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sw", int'(sw_int_reset), 1);
    chk("abort_refmux", int'(refmux), 0);
    chk("abort_count_pos", int'(count_pos), 0);
    chk("abort_count_neg", int'(count_neg), 0);
    chk("abort_monitor", int'(monitor), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_check(6);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check(10);
    chk("reset_count_pos", int'(count_pos), 0);
    chk("reset_count_neg", int'(count_neg), 0);
    chk("reset_done", int'(adc_measure_done), 0);

    run_conv(10, 1, 0, 1'b0);   // 3 windows, all -ref
    idle_check(2);
    run_conv(16, 2, 0, 1'b0);   // 4 windows, +ref/-ref alternating
    idle_check(2);
    run_conv(0, 0, 0, 1'b0);    // minimum single window
    idle_check(1);
    run_conv(12, 0, 1, 1'b0);   // start re-pulsed while busy and in DONE
    idle_check(3);
    run_conv(9, 0, 2, 1'b1);    // start held: retriggers on first IDLE cycle
    run_conv(5, 0, 0, 1'b0);
    idle_check(2);
    abort_test();
    run_conv(13, 0, 0, 1'b0);
    idle_check(2);

    for (int t = 0; t < 16; t++) begin
      run_conv(int'($urandom_range(0, 40)), 0, int'($urandom_range(0, 1)), 1'b0);
      idle_check(int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("missing_done", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
